// File: rtl/ahb_slv_sram.sv
// ahb_slv_sram: AHB-Lite slave over a word-organised SRAM with programmable wait states.
module ahb_slv_sram #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready_in,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hready_out,
  output logic [1:0]        hresp
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [1:0] lo_q;
  logic wr_q;
  logic [2:0] size_q;
  logic [DWIDTH-1:0] mem [2**DEPTH_LOG2];
  logic accept, err;
  logic [3:0] be;
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};
  // Address phases are only taken in states where this slave drives hready high.
  assign accept = (state_q == S_IDLE || state_q == S_LAST || state_q == S_ERR2) &&
                  hsel && hready_in && htrans[1];
  assign err = ((haddr >> (DEPTH_LOG2 + 2)) != '0) || (hsize > 3'b010) ||
               (hsize == 3'b001 && haddr[0]) || (hsize == 3'b010 && haddr[1:0] != 2'b00);
  always_comb begin
    state_d = !accept ? S_IDLE : err ? S_ERR1 : (WAIT_STATES > 0 ? S_WAIT : S_LAST);
    cnt_d   = accept ? 4'd0 : cnt_q;
    if (state_q == S_WAIT) begin
      state_d = (cnt_q == WS_LAST) ? S_LAST : S_WAIT;
      cnt_d   = cnt_q + 4'd1;
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q  <= haddr[DEPTH_LOG2+1:2];
        lo_q   <= haddr[1:0];
        wr_q   <= hwrite;
        size_q <= hsize;
      end
    end
  end
  assign be = (size_q == 3'b000) ? (4'b0001 << lo_q) :
              (size_q == 3'b001) ? (lo_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge hclk) begin
    if (state_q == S_LAST && wr_q)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
  end
  always_comb begin
    hready_out = !(state_q == S_WAIT || state_q == S_ERR1);
    hresp      = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
    hrdata     = (state_q == S_LAST) ? mem[idx_q] : '0;
  end
endmodule

// File: tb/tb_ahb_slv_sram.sv
// tb_ahb_slv_sram: directed AHB transfers against a zero-wait and a three-wait instance, checked by a transaction model.
module tb_ahb_slv_sram;
  typedef struct {
    logic       rdy;
    logic [1:0] resp;
    bit         last;
    bit         wr;
    int         idx;
    logic [1:0] lo;
    logic [2:0] sz;
  } exp_t;

  logic clk = 0, hresetn = 1, sel = 0, stall = 0, hwrite = 0, chk_on = 0;
  int tgt = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0;
  logic [31:0] hrdata0, hrdata3;
  logic hready_out0, hready_out3;
  logic [1:0] hresp0, hresp3;
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ahb_slv_sram #(.WAIT_STATES(0)) dut0 (
    .hclk(clk), .hresetn(hresetn), .hsel(sel && tgt == 0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b011), .hwdata(hwdata),
    .hready_in(hready_out0 && !stall), .hrdata(hrdata0), .hready_out(hready_out0), .hresp(hresp0));
  ahb_slv_sram #(.WAIT_STATES(3)) dut3 (
    .hclk(clk), .hresetn(hresetn), .hsel(sel && tgt == 1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b001), .hwdata(hwdata),
    .hready_in(hready_out3 && !stall), .hrdata(hrdata3), .hready_out(hready_out3), .hresp(hresp3));

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted transfer expands into its per-cycle response schedule.
  logic [31:0] mm [2][256];
  exp_t q0[$], q1[$];

  function automatic int qn(int d);
    return d ? q1.size() : q0.size();
  endfunction
  function automatic exp_t front(int d);
    return d ? q1[0] : q0[0];
  endfunction
  task automatic push(int d, exp_t e);
    if (d) q1.push_back(e); else q0.push_back(e);
  endtask

  always @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit ready, bad_xfer;
        exp_t f, e;
        ready = qn(d) == 0 || front(d).rdy;
        if (qn(d) != 0) begin
          f = front(d);
          if (f.last && f.wr)
            for (int b = 0; b < 4; b++)
              if (f.sz == 0 ? b == int'(f.lo) : f.sz == 1 ? b / 2 == int'(f.lo[1]) : 1'b1)
                mm[d][f.idx][8*b +: 8] = hwdata[8*b +: 8];
          if (d) void'(q1.pop_front()); else void'(q0.pop_front());
        end
        if (ready && sel && tgt == d && htrans[1] && !stall) begin
          bad_xfer = haddr >= 32'd1024 || hsize > 2 || (hsize == 1 && haddr % 2 != 0) ||
                     (hsize == 2 && haddr % 4 != 0);
          e = '{rdy: 1'b0, resp: 2'b00, last: 0, wr: 0, idx: 0, lo: 2'b00, sz: 3'b000};
          if (bad_xfer) begin
            e.resp = 2'b01;
            push(d, e);
            e.rdy = 1'b1;
            push(d, e);
          end else begin
            repeat (d ? 3 : 0) push(d, e);
            e.rdy = 1'b1; e.last = 1; e.wr = hwrite; e.idx = int'(haddr / 4);
            e.lo = haddr[1:0]; e.sz = hsize;
            push(d, e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on)
      for (int d = 0; d < 2; d++) begin
        logic er;
        logic [1:0] ep;
        logic [31:0] ed;
        exp_t f;
        er = 1'b1; ep = 2'b00; ed = 32'h0;
        if (qn(d) != 0) begin
          f = front(d);
          er = f.rdy; ep = f.resp; ed = f.last ? mm[d][f.idx] : 32'h0;
        end
        cmp(d ? "d3_hready" : "d0_hready", d ? 32'(hready_out3) : 32'(hready_out0), 32'(er));
        cmp(d ? "d3_hresp" : "d0_hresp", d ? 32'(hresp3) : 32'(hresp0), 32'(ep));
        cmp(d ? "d3_hrdata" : "d0_hrdata", d ? hrdata3 : hrdata0, ed);
      end
  end

  // Pipelined beat list and per-beat completion records.
  logic bw[8];
  logic [31:0] ba[8], bd[8];
  logic [2:0] bs[8];
  int waits[8], done_cyc[8];
  logic [31:0] rd[8];
  logic [1:0] rsp[8];

  task automatic beat(int i, logic w, logic [31:0] a, logic [2:0] s, logic [31:0] dat);
    bw[i] = w; ba[i] = a; bs[i] = s; bd[i] = dat;
  endtask

  task automatic burst(int d, int n);
    for (int i = 0; i <= n; i++) begin
      int g;
      logic r;
      sel = i < n; tgt = d; htrans = i < n ? 2'b10 : 2'b00;
      if (i < n) begin hwrite = bw[i]; haddr = ba[i]; hsize = bs[i]; end
      if (i > 0) hwdata = bd[i-1];
      g = 0;
      if (i > 0) waits[i-1] = 0;
      forever begin
        @(negedge clk);
        r = d ? hready_out3 : hready_out0;
        if (r || g >= 50) break;
        g++;
        if (i > 0) waits[i-1]++;
      end
      if (!r) begin
        total++; bad++;
        $display("FAIL timeout d=%0d beat=%0d", d, i);
      end
      if (i > 0) begin
        rd[i-1] = d ? hrdata3 : hrdata0;
        rsp[i-1] = d ? hresp3 : hresp0;
        done_cyc[i-1] = cyc;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic raw(logic s, int t, logic [1:0] tr, logic [31:0] a, logic stl);
    sel = s; tgt = t; htrans = tr; hwrite = 1'b1; haddr = a; hsize = 3'b010;
    hwdata = 32'hFFFF_FFFF; stall = stl;
    @(posedge clk); #2;
  endtask

  initial begin
    #1 hresetn = 0;
    chk_on = 1;
    repeat (3) @(posedge clk);
    #2 hresetn = 1;
    @(negedge clk);
    cmp("rst_hready", 32'(hready_out0), 32'd1);
    cmp("rst_hresp", 32'(hresp0), 32'd0);
    cmp("rst_hrdata", hrdata0, 32'd0);
    @(posedge clk); #2;

    beat(0, 1, 32'h10, 3'b010, 32'hDEADBEEF);
    beat(1, 0, 32'h10, 3'b010, 32'h0);
    burst(0, 2);
    cmp("raw_data", rd[1], 32'hDEADBEEF);
    cmp("raw_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd1);
    cmp("raw_nostall", 32'(waits[0] + waits[1]), 32'd0);

    beat(0, 1, 32'h10, 3'b010, 32'h0);
    beat(1, 1, 32'h11, 3'b000, 32'h5555AA55);
    beat(2, 0, 32'h10, 3'b010, 32'h0);
    beat(3, 1, 32'h12, 3'b001, 32'hBEEF1234);
    beat(4, 0, 32'h10, 3'b010, 32'h0);
    burst(0, 5);
    cmp("byte_lane", rd[2], 32'h0000AA00);
    cmp("half_lane", rd[4], 32'hBEEFAA00);

    beat(0, 1, 32'h20, 3'b010, 32'hCAFEF00D);
    burst(1, 1);
    beat(0, 0, 32'h20, 3'b010, 32'h0);
    burst(1, 1);
    cmp("ws3_waits", 32'(waits[0]), 32'd3);
    cmp("ws3_data", rd[0], 32'hCAFEF00D);
    cmp("ws3_resp", 32'(rsp[0]), 32'd0);

    beat(0, 1, 32'h0, 3'b010, 32'h01020304);
    burst(0, 1);
    beat(0, 1, 32'h400, 3'b010, 32'h11111111);
    burst(0, 1);
    cmp("oor_resp", 32'(rsp[0]), 32'd1);
    cmp("oor_waits", 32'(waits[0]), 32'd1);
    beat(0, 1, 32'h2, 3'b010, 32'h22222222);
    burst(0, 1);
    cmp("misal_resp", 32'(rsp[0]), 32'd1);
    cmp("misal_waits", 32'(waits[0]), 32'd1);
    beat(0, 1, 32'h0, 3'b011, 32'h33333333);
    burst(0, 1);
    cmp("size_resp", 32'(rsp[0]), 32'd1);
    cmp("size_waits", 32'(waits[0]), 32'd1);
    beat(0, 0, 32'h0, 3'b010, 32'h0);
    burst(0, 1);
    cmp("err_nowrite", rd[0], 32'h01020304);

    raw(1, 0, 2'b01, 32'h0, 0);
    raw(1, 0, 2'b00, 32'h0, 0);
    raw(0, 0, 2'b10, 32'h0, 0);
    raw(1, 0, 2'b10, 32'h0, 1);
    raw(1, 0, 2'b11, 32'h0, 1);
    raw(0, 0, 2'b00, 32'h0, 0);
    burst(0, 1);
    cmp("ctl_nowrite", rd[0], 32'h01020304);

    raw(1, 1, 2'b10, 32'h20, 0);
    sel = 0; htrans = 2'b00; hwdata = 32'h0BADF00D;
    @(posedge clk); #2;
    hresetn = 0;
    @(negedge clk);
    cmp("rstw_hready", 32'(hready_out3), 32'd1);
    cmp("rstw_hresp", 32'(hresp3), 32'd0);
    @(posedge clk); #2;
    hresetn = 1;
    beat(0, 0, 32'h20, 3'b010, 32'h0);
    burst(1, 1);
    cmp("rstw_nowrite", rd[0], 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_slv_sram.md
Name: ahb_slv_sram

Overview:
- AHB-Lite slave holding a word-organised on-chip SRAM model with programmable wait states.
- Sits directly downstream of the Wishbone-to-AHB bridge. Consumes its haddr/htrans/hwrite/hsize/hburst/hwdata and returns hrdata/hready/hresp.
- Serves as the bridge's system-level target and as the bus endpoint for WB-side regression.

Parameters:
- AWIDTH, 32: address width.
- DWIDTH, 32: data width. Only 32 is supported.
- DEPTH_LOG2, 8: log2 of the memory depth in 32-bit words. Default is 256 words = 1 KiB.
- WAIT_STATES, 0: hready_out-low cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- hclk  in  1  AHB clock; all logic on the rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hsel  in  1  slave select, address phase.
- haddr  in  AWIDTH  byte address.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  000 byte, 001 half, 010 word; others illegal.
- hburst  in  3  ignored. Each beat is decoded from its own address phase.
- hwdata  in  DWIDTH  write data, valid in the data phase.
- hready_in  in  1  bus-level hready; the address phase is taken only when this is 1.
- hrdata  out  DWIDTH  read data.
- hready_out  out  1  slave ready.
- hresp  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset (hresetn=0, asynchronous):
  - State goes to IDLE; the wait counter and all latched address-phase registers clear.
  - Outputs: hready_out=1, hresp=00, hrdata=0.
  - Memory contents are not reset.
  - A reset asserted mid data phase aborts the transfer; no memory write occurs.
- Address-phase accept: hsel & hready_in & htrans[1] at a rising edge.
  - Latches word index haddr[DEPTH_LOG2+1:2], haddr[1:0], hwrite and hsize.
  - IDLE or BUSY (htrans[1]=0), or hsel=0: nothing is latched. The next cycle gives a zero-wait OKAY (hready_out=1, hresp=00).
- Error check, performed at accept. Any of the following causes an ERROR response:
  - haddr[AWIDTH-1:DEPTH_LOG2+2] != 0 (out of range);
  - hsize > 010;
  - halfword with haddr[0]=1;
  - word with haddr[1:0] != 00.
- State machine:
  - IDLE: accept OK -> WAIT if WAIT_STATES>0, otherwise LAST. Accept error -> ERR1. No accept -> IDLE.
  - WAIT: hready_out=0, hresp=00; counts WAIT_STATES cycles, then -> LAST.
  - LAST: hready_out=1, hresp=00. Performs the access (below). The same edge may accept the next address phase; next state follows the IDLE rules.
  - ERR1: hready_out=0, hresp=01 -> ERR2.
  - ERR2: hready_out=1, hresp=01. A new accept is allowed on this edge; the master normally drives IDLE here, and NONSEQ is honoured if presented.
- Write, at the LAST edge:
  - Byte enables come from the latched size and addr[1:0], little-endian (addr 0 -> bits 7:0).
  - Byte: 1 lane. Half: lanes {1,0} or {3,2}. Word: all 4 lanes.
  - Only the enabled lanes of hwdata are stored.
  - Error transfers never write.
- Read:
  - In LAST, hrdata = the full aligned word mem[index], driven combinationally from the latched index. The master selects the lanes.
  - In every other state hrdata = 0.
- Read-after-write to the same word in back-to-back transfers returns the new data, because the write commits at the LAST edge, before the read's data phase.
- Pipelining: with WAIT_STATES=0, back-to-back NONSEQ/SEQ complete one per cycle.
- hready_in=0 while this slave is IDLE (another slave stalling): no accept, outputs stay OKAY/ready.

Test Plan:
- Reset: hresetn low for 3 cycles, then release -> hready_out=1, hresp=00, hrdata=0.
- WAIT_STATES=0:
  - Write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> read data phase one cycle after the write, hrdata=0xDEADBEEF, no stalls.
  - Byte write 0xAA @0x11 over 0x00000000, then word read @0x10 -> 0x0000AA00.
- WAIT_STATES=3: read @0x20 -> hready_out low for exactly 3 cycles, then high with valid data and hresp=00.
- Errors:
  - Write @0x400 (out of range at DEPTH_LOG2=8) -> ERR1: hready_out=0, hresp=01; ERR2: hready_out=1, hresp=01; memory unchanged on readback.
  - Word @0x02 -> same two-cycle ERROR.
  - hsize=011 -> same two-cycle ERROR.
- Controls:
  - BUSY/IDLE htrans, and hsel=0 with NONSEQ -> zero-wait OKAY, no write.
  - hresetn pulsed during a WAIT cycle of a write -> immediate ready/OKAY; target word unchanged.
